// File: rtl/lab7_soc_pio_in_irq.sv
// Avalon-MM input PIO: synchronised, debounced inputs with edge capture, IRQ mask and
// level interrupt. Reads are side-effect free and registered (one cycle latency).
module lab7_soc_pio_in_irq #(
    parameter int unsigned     WIDTH       = 4,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     DEBOUNCE    = 16,
    parameter int unsigned     EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A zero-width counter is illegal, so bypass mode still carries a 1-bit counter.
    localparam int unsigned CntW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (DEBOUNCE > 0) ? CntW'(DEBOUNCE - 1) : '0;

    localparam logic [1:0] AddrData    = 2'd0;
    localparam logic [1:0] AddrMask    = 2'd2;
    localparam logic [1:0] AddrCapture = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]                  deb_q, deb_d;
    logic [WIDTH-1:0]                  deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [31:0]                       rd_q, rd_d;
    logic                              irq_q, irq_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;
    logic             unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Per-bit debounce: a change must persist DEBOUNCE cycles; any return to the
    // accepted value restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (DEBOUNCE == 0) begin
                deb_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else if (sync_out[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                deb_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_comb begin
        deb_prev_d = deb_q;
        rise       = deb_q & ~deb_prev_q;
        fall       = ~deb_q & deb_prev_q;
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
    end

    always_comb begin
        wr_en    = chipselect & ~write_n;
        wr_mask  = wr_en && (address == AddrMask);
        wr_cap   = wr_en && (address == AddrCapture);
        clr_bits = wr_cap ? writedata[WIDTH-1:0] : '0;

        mask_d = wr_mask ? writedata[WIDTH-1:0] : mask_q;
        // New edges override a same-cycle clear so no event is lost.
        cap_d  = (cap_q & ~clr_bits) | edge_det;
        irq_d  = |(cap_d & mask_d);
    end

    always_comb begin
        rd_d = '0;
        case (address)
            AddrData:    rd_d = 32'(deb_q);
            AddrMask:    rd_d = 32'(mask_q);
            AddrCapture: rd_d = 32'(cap_q);
            default:     rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q      <= '0;
            deb_q      <= RESET_VALUE;
            deb_prev_q <= RESET_VALUE;
            mask_q     <= '0;
            cap_q      <= '0;
            rd_q       <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rd_q       <= rd_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_lab7_soc_pio_in_irq.sv
// Directed bench: a rising-edge DUT (reset value 0) and a falling-edge DUT (reset value
// all-ones) sharing clock, reset and bus; each has its own input port.
module tb_lab7_soc_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lab7_soc_pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(0), .RESET_VALUE(4'h0)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    lab7_soc_pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    localparam int NVec = 14;
    vec_t vecs [NVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk_a(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check(name, rd_a, exp);
    endtask

    task automatic rd_chk_b(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check(name, rd_b, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // cs wn addr wdata chk exp irq
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFF5, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'h5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'hF,         1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'hF,         1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'hF,         1'b0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 32'hA,         1'b0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b0, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h0, 1'b0};

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 4'h0;
        in_b       = 4'hF;
        ticks(2);
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_irq_a", 32'(irq_a), 32'h0);
        check("reset_rd_b", rd_b, 32'h0);
        reset = 1'b0;

        address = 2'd0;
        tick();
        check("post_reset_data_a", rd_a, 32'h0);
        check("post_reset_data_b", rd_b, 32'hF);
        address = 2'd3;
        tick();
        check("post_reset_cap_a", rd_a, 32'h0);
        check("post_reset_cap_b", rd_b, 32'h0);

        // Register access table
        for (int i = 0; i < NVec; i++) begin
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            tick();
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(vecs[i].exp_irq));
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Step on bit0: debounced value changes exactly 6 cycles later
        address = 2'd0;
        in_a    = 4'h1;
        ticks(6);
        check("t1_data_before", rd_a, 32'h0);
        tick();
        check("t1_data_after", rd_a, 32'h1);
        rd_chk_a("t1_cap", 2'd3, 32'h1);
        check("t1_irq_masked", 32'(irq_a), 32'h0);
        bus_wr(2'd3, 32'h1);
        rd_chk_a("t1_cap_cleared", 2'd3, 32'h0);

        // 3-cycle glitch on bit2 is rejected
        in_a = 4'h5;
        ticks(3);
        in_a = 4'h1;
        ticks(12);
        rd_chk_a("t2_data", 2'd0, 32'h1);
        rd_chk_a("t2_cap", 2'd3, 32'h0);
        check("t2_irq", 32'(irq_a), 32'h0);

        // Masked rising edge on bit1 raises irq; clearing drops it
        bus_wr(2'd2, 32'h2);
        in_a    = 4'h3;
        address = 2'd3;
        ticks(6);
        check("t3_irq_before", 32'(irq_a), 32'h0);
        tick();
        check("t3_irq_set", 32'(irq_a), 32'h1);
        tick();
        check("t3_cap", rd_a, 32'h2);
        bus_wr(2'd3, 32'h2);
        check("t3_irq_cleared", 32'(irq_a), 32'h0);
        rd_chk_a("t3_cap_cleared", 2'd3, 32'h0);

        // Falling edge not captured in rising mode
        in_a = 4'h1;
        ticks(10);
        rd_chk_a("t4_fall_ignored", 2'd3, 32'h0);

        // Clear in the same cycle as a new edge: capture survives
        in_a = 4'h3;
        ticks(6);
        bus_wr(2'd3, 32'h2);
        check("t4_irq_set_wins", 32'(irq_a), 32'h1);
        rd_chk_a("t4_cap_set_wins", 2'd3, 32'h2);
        bus_wr(2'd2, 32'h0);
        check("t4_irq_mask_off", 32'(irq_a), 32'h0);
        rd_chk_a("t4_cap_kept", 2'd3, 32'h2);
        bus_wr(2'd2, 32'h2);
        check("t4_irq_mask_on", 32'(irq_a), 32'h1);

        // Reset with a pending interrupt
        reset = 1'b1;
        tick();
        check("t6_rd_in_reset", rd_a, 32'h0);
        check("t6_irq_in_reset", 32'(irq_a), 32'h0);
        reset = 1'b0;
        rd_chk_a("t6_cap", 2'd3, 32'h0);
        rd_chk_a("t6_mask", 2'd2, 32'h0);
        rd_chk_a("t6_data", 2'd0, 32'h0);
        check("t6_irq", 32'(irq_a), 32'h0);

        // Falling-edge DUT with all-ones reset value
        rd_chk_b("t5_cap_after_reset", 2'd3, 32'h0);
        in_b = 4'h7;
        ticks(10);
        rd_chk_b("t5_cap_fall", 2'd3, 32'h8);
        rd_chk_b("t5_data_low", 2'd0, 32'h7);
        check("t5_irq_unmasked", 32'(irq_b), 32'h0);
        bus_wr(2'd3, 32'h8);
        in_b = 4'hF;
        ticks(10);
        rd_chk_b("t5_no_rise_cap", 2'd3, 32'h0);
        rd_chk_b("t5_data_high", 2'd0, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
